// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller for a 5-stage MIPS-style core.
//
// Owns the architectural HI/LO registers. A mult/multu/div/divu issued from
// the E stage computes its result in one step into internal pending
// registers. It then holds busy for MULT_CYCLES / DIV_CYCLES cycles and
// commits the result to HI/LO on the last busy edge. mthi/mtlo write HI/LO
// directly and never raise busy.
//
// Parameters:
//   MULT_CYCLES  busy duration of mult/multu (1..15)
//   DIV_CYCLES   busy duration of div/divu   (1..15)
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   start      in   E-stage issue strobe for a mult/div-class instruction
//   md_op      in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   src_a      in   forwarded rs value
//   src_b      in   forwarded rt value
//   d_md_use   in   D-stage instruction uses the MDU or HI/LO
//   cancel     in   abort in-flight operation (only with MDU_CANCEL_EN)
//   busy       out  multi-cycle operation in flight
//   stall_req  out  freeze PC/FD and clear DE
//   hi, lo     out  architectural HI / LO
//
// Build option: define MDU_CANCEL_EN to add the cancel port.
// ---------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_md_use,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   // Cleared for divide-by-zero so that completion leaves HI/LO untouched.
   logic        pend_wr_q, pend_wr_d;

   // ------------------------------------------------------------------
   // Arithmetic datapath (single-step; the busy count models latency)
   // ------------------------------------------------------------------
   logic [63:0] a_sx, b_sx, prod_s, prod_u, prod;
   logic        div_signed, neg_a, neg_b;
   logic [31:0] abs_a, abs_b, divisor, uq, ur, quot, rem;

   always_comb begin : datapath
      a_sx   = {{32{src_a[31]}}, src_a};
      b_sx   = {{32{src_b[31]}}, src_b};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, src_a} * {32'd0, src_b};
      prod   = md_op[0] ? prod_u : prod_s;

      // Signed divide via magnitudes: this makes 0x80000000 / -1 fall out
      // naturally as 0x80000000 rem 0 instead of relying on overflow
      // behaviour of a native signed divide.
      div_signed = ~md_op[0];
      neg_a      = div_signed & src_a[31];
      neg_b      = div_signed & src_b[31];
      abs_a      = neg_a ? (32'd0 - src_a) : src_a;
      abs_b      = neg_b ? (32'd0 - src_b) : src_b;
      // Substitute 1 for a zero divisor; the result is discarded anyway.
      divisor    = (abs_b == 32'd0) ? 32'd1 : abs_b;
      uq         = abs_a / divisor;
      ur         = abs_a % divisor;
      quot       = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
      rem        = neg_a ? (32'd0 - ur) : ur;   // remainder takes dividend sign
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin : next_state
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (md_op)
                  3'd0, 3'd1: begin
                     pend_hi_d = prod[63:32];
                     pend_lo_d = prod[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = MULT_LOAD;
                     state_d   = S_MUL;
                  end
                  3'd2, 3'd3: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     pend_wr_d = (src_b != 32'd0);
                     cnt_d     = DIV_LOAD;
                     state_d   = S_DIV;
                  end
                  3'd4:    hi_d = src_a;
                  3'd5:    lo_d = src_a;
                  default: ;
               endcase
            end
         end
         // Starts arriving here are ignored: the hazard unit never
         // issues into a busy MDU.
         S_MUL, S_DIV: begin
            if (cnt_q == 4'd0) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d   = S_IDLE;
               pend_hi_d = 32'd0;
               pend_lo_d = 32'd0;
               pend_wr_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef MDU_CANCEL_EN
      // Cancel beats both completion and a simultaneous start.
      if (cancel) begin
         state_d   = S_IDLE;
         cnt_d     = 4'd0;
         hi_d      = hi_q;
         lo_d      = lo_q;
         pend_hi_d = 32'd0;
         pend_lo_d = 32'd0;
         pend_wr_d = 1'b0;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin : outputs
      busy      = (state_q != S_IDLE);
      stall_req = d_md_use & (start | busy);
      hi        = hi_q;
      lo        = lo_q;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mdu_ctrl. Stimulus pushes the expected HI/LO and busy length
// of each transaction into a queue; a monitor on the falling edge pops and
// compares whenever busy drops or HI/LO change.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd7;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        d_md_use = 1'b0;
`ifdef MDU_CANCEL_EN
   logic        cancel = 1'b0;
`endif
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .d_md_use  (d_md_use),
`ifdef MDU_CANCEL_EN
      .cancel    (cancel),
`endif
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [7:0]  nb;   // expected busy cycles observed before the event
      logic [7:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   busy_run = 0;
   logic        prev_busy = 1'b0;
   logic [31:0] prev_hi   = 32'd0;
   logic [31:0] prev_lo   = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic expect_txn(input logic [7:0] id, input logic [31:0] h,
                             input logic [31:0] l, input logic [7:0] nb);
      exp_t e;
      e.hi = h; e.lo = l; e.nb = nb; e.id = id;
      exp_q.push_back(e);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      logic ev;
      if (busy === 1'b1) busy_run++;
      ev = (prev_busy === 1'b1 && busy === 1'b0) || (hi !== prev_hi) || (lo !== prev_lo);
      if (ev) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got hi=%h lo=%h expected no change", hi, lo);
         end else begin
            e = exp_q.pop_front();
            $display("txn %0d: hi=%h lo=%h busy_cycles=%0d", e.id, hi, lo, busy_run);
            chk($sformatf("txn%0d_hi", e.id), hi, e.hi);
            chk($sformatf("txn%0d_lo", e.id), lo, e.lo);
            chk($sformatf("txn%0d_busy_cycles", e.id), 32'(busy_run), 32'(e.nb));
         end
         busy_run = 0;
      end
      prev_busy = busy;
      prev_hi   = hi;
      prev_lo   = lo;
   end

   // Issue one instruction; entered and left at posedge+1.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd7;
   endtask

   // Bounded wait for the scoreboard to drain.
   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      // ---------------- reset state ----------------
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      d_md_use = 1'b1; start = 1'b1;
      #1 chk("reset_stall_start", 32'(stall_req), 32'd1);
      start = 1'b0;
      #1 chk("reset_stall_idle", 32'(stall_req), 32'd0);
      d_md_use = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      // ---------------- arithmetic ----------------
      expect_txn(1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      issue(3'd0, 32'hFFFFFFFF, 32'd2);            // mult  -1*2
      drain("mult");
      expect_txn(2, 32'h00000001, 32'hFFFFFFFE, 5);
      issue(3'd1, 32'hFFFFFFFF, 32'd2);            // multu
      drain("multu");
      expect_txn(3, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(3'd2, 32'hFFFFFFF9, 32'd2);            // div -7/2
      drain("div");
      expect_txn(4, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(3'd2, 32'hFFFFFFF9, 32'd0);            // div by zero: unchanged
      drain("div0");

      // ---------------- mthi / mtlo back to back ----------------
      expect_txn(5, 32'h12345678, 32'hFFFFFFFD, 0);
      expect_txn(6, 32'h12345678, 32'h9ABCDEF0, 0);
      issue(3'd4, 32'h12345678, 32'd0);
      issue(3'd5, 32'h9ABCDEF0, 32'd0);
      drain("mthi_mtlo");

      // ---------------- boundaries ----------------
      expect_txn(7, 32'h00000000, 32'h80000000, 10);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);     // signed overflow case
      drain("div_ovf");
      expect_txn(8, 32'h0000000F, 32'h0FFFFFFF, 10);
      issue(3'd3, 32'hFFFFFFFF, 32'h00000010);     // divu
      drain("divu");
      expect_txn(9, 32'h00000001, 32'hFFFFFFFD, 10);
      issue(3'd2, 32'd7, 32'hFFFFFFFE);            // 7 / -2 = -3 rem 1
      drain("div_negb");
      expect_txn(10, 32'h00000001, 32'h00000000, 5);
      issue(3'd0, 32'h00010000, 32'h00010000);     // 2^32
      drain("mult_carry");
      issue(3'd6, 32'hDEADBEEF, 32'd1);            // no-op: no event expected
      issue(3'd7, 32'hDEADBEEF, 32'd1);
      repeat (3) @(posedge clk);
      #1;

      // ---------------- stall across full div ----------------
      d_md_use = 1'b1;
      expect_txn(11, 32'd2, 32'd14, 10);
      start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      chk("stall_start_cycle", 32'(stall_req), 32'd1);
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd7;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("stall_busy_cycle%0d", i + 1), 32'(stall_req), 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("stall_after_done", 32'(stall_req), 32'd0);
      @(posedge clk); #1;
      drain("div_stall");

      // ---------------- reset mid-operation ----------------
      expect_txn(12, 32'd0, 32'd0, 3);
      issue(3'd2, 32'd100, 32'd7);
      repeat (3) begin @(posedge clk); #1; end    // now in busy cycle 4
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      chk("rst_mid_stall", 32'(stall_req), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      d_md_use = 1'b0;
      repeat (15) begin @(posedge clk); #1; end   // any late write is flagged
      drain("reset_mid");

      // ---------------- cancel on last busy cycle ----------------
      expect_txn(13, 32'hAAAA5555, 32'd0, 0);
      expect_txn(14, 32'hAAAA5555, 32'h5555AAAA, 0);
      issue(3'd4, 32'hAAAA5555, 32'd0);
      issue(3'd5, 32'h5555AAAA, 32'd0);
      drain("preload");
`ifdef MDU_CANCEL_EN
      expect_txn(15, 32'hAAAA5555, 32'h5555AAAA, 5);
`else
      expect_txn(15, 32'h00000000, 32'h0000000F, 5);
`endif
      issue(3'd0, 32'd3, 32'd5);
      repeat (4) begin @(posedge clk); #1; end    // now in busy cycle 5
`ifdef MDU_CANCEL_EN
      cancel = 1'b1;
`endif
      @(posedge clk); #1;
`ifdef MDU_CANCEL_EN
      cancel = 1'b0;
`endif
      drain("cancel");

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu in cycles (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu in cycles (legal range 1..15).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: E-stage issue strobe for a mult/div-class instruction.
REQ-006 Port md_op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 SHALL be no-ops.
REQ-007 Port src_a, input, 32 bits: forwarded rs value from E stage.
REQ-008 Port src_b, input, 32 bits: forwarded rt value from E stage.
REQ-009 Port d_md_use, input, 1 bit: the D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 Port busy, output, 1 bit: a multi-cycle operation is in flight.
REQ-011 Port stall_req, output, 1 bit: request to the hazard unit to freeze PC/FD and clear DE.
REQ-012 Port hi, output, 32 bits: architectural HI register.
REQ-013 Port lo, output, 32 bits: architectural LO register.
REQ-014 Port cancel, input, 1 bit: present only when MDU_CANCEL_EN is defined (see Configuration).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, MUL, DIV.
REQ-016 In IDLE, a start with md_op 0/1 sampled at an edge SHALL compute the 64-bit product (signed for 0, unsigned for 1) into internal pending registers, load the counter with MULT_CYCLES-1, and enter MUL.
REQ-017 In IDLE, a start with md_op 2/3 SHALL compute quotient and remainder (signed for 2, unsigned for 3) into pending registers, load the counter with DIV_CYCLES-1, and enter DIV.
REQ-018 In MUL or DIV, the counter SHALL decrement each edge; at the edge where it equals 0, hi and lo SHALL take the pending high/remainder and low/quotient values, and the state SHALL return to IDLE.
REQ-019 busy SHALL be 1 exactly when the state is MUL or DIV, i.e. for N cycles after the start edge, where N = MULT_CYCLES or DIV_CYCLES; the new hi/lo SHALL be visible in the first cycle busy is 0.
REQ-020 In IDLE, a start with md_op 4 SHALL write src_a into hi, and md_op 5 SHALL write src_a into lo, at that edge, with no busy cycle.
REQ-021 A start while busy SHALL be ignored with no state change; the hazard contract guarantees that this does not occur.
REQ-022 stall_req SHALL equal d_md_use & (start | busy), combinationally.
REQ-023 Divide by zero SHALL complete with normal latency and leave hi and lo unchanged.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000.
REQ-025 Pending registers SHALL be internal; hi and lo SHALL change only at completion or on mthi/mtlo.

Reset
REQ-026 When reset asserts at any time, including mid-operation, state SHALL become IDLE, the counter 0, busy 0, hi 0, lo 0, and pending results SHALL be discarded.
REQ-027 stall_req during reset SHALL follow REQ-022 with busy=0.

Configuration
REQ-028 When macro MDU_CANCEL_EN is defined, port cancel SHALL exist, and cancel=1 at an edge SHALL force IDLE, discard pending results, and leave hi/lo unchanged.
REQ-029 cancel SHALL take priority over completion in the same cycle and SHALL block a simultaneous start.
REQ-030 When MDU_CANCEL_EN is undefined, the cancel port SHALL be absent and in-flight operations SHALL always complete.

Verification
REQ-031 mult with src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFE.
REQ-032 multu with the same operands -> hi=0x00000001 and lo=0xFFFFFFFE after 5 busy cycles.
REQ-033 div with src_a=-7, src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; repeat with divisor 0 -> hi/lo unchanged.
REQ-034 mthi with 0x12345678 while idle -> hi=0x12345678 next cycle, busy never high; mtlo in the following cycle -> lo updated and hi intact.
REQ-035 div started and d_md_use held 1 -> stall_req high from the start cycle through all 10 busy cycles; reset asserted on busy cycle 4 -> busy=0, hi=lo=0 immediately, and no later write occurs.
REQ-036 With MDU_CANCEL_EN, cancel on the last busy cycle of mult -> busy=0 and hi/lo keep their prior values; without the macro the same stimulus (cancel absent) -> result committed.
